// File: rtl/id_stage_pipe_pkg.sv
// Shared constants and helpers for the decode stage: index width, field offsets
// and the opcode EX uses to flag loads.
package id_stage_pipe_pkg;

  localparam logic [4:0] OPC_LOAD = 5'd2;

  function automatic int ridx_of(input int nreg);
    return (nreg <= 2) ? 1 : $clog2(nreg);
  endfunction

  function automatic int imm_width(input int xlen, input int opw, input int ridx);
    return xlen - opw - 3 * ridx;
  endfunction

  function automatic int rd_lsb(input int xlen, input int opw, input int ridx);
    return xlen - opw - ridx;
  endfunction

  function automatic int rs1_lsb(input int xlen, input int opw, input int ridx);
    return xlen - opw - 2 * ridx;
  endfunction

  function automatic int rs2_lsb(input int xlen, input int opw, input int ridx);
    return xlen - opw - 3 * ridx;
  endfunction

endpackage

// File: rtl/id_stage_pipe_regfile_nr.sv
// Architectural register file: two combinational read ports, one write port,
// write-through to the read ports, optional hard-wired zero register.
module regfile_nr
  import id_stage_pipe_pkg::*;
#(
  parameter int XLEN     = 19,
  parameter int NREG     = 8,
  parameter int ZERO_REG = 1,
  parameter int RIDX     = ridx_of(NREG)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            we,
  input  logic [RIDX-1:0] waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [RIDX-1:0] raddr1,
  input  logic [RIDX-1:0] raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] r_regs [NREG];

  logic w_we_eff;
  logic w_zero1, w_zero2;
  logic w_hit1, w_hit2;

  assign w_we_eff = we && !((ZERO_REG != 0) && (waddr == '0));

  // NOTE: the array is cleared on reset because an architectural reset must leave
  // every register at zero; this keeps it in flops rather than a RAM macro.
  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together at the edge regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_we_eff) begin
      r_regs[waddr] <= wdata;
    end
  end

  assign w_zero1 = (ZERO_REG != 0) && (raddr1 == '0);
  assign w_zero2 = (ZERO_REG != 0) && (raddr2 == '0);
  assign w_hit1  = w_we_eff && (waddr == raddr1);
  assign w_hit2  = w_we_eff && (waddr == raddr2);

  // A write in flight is forwarded so a same-cycle read sees the new value.
  assign rdata1 = w_zero1 ? '0 : (w_hit1 ? wdata : r_regs[raddr1]);
  assign rdata2 = w_zero2 ? '0 : (w_hit2 ? wdata : r_regs[raddr2]);

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage: slices instruction fields, reads operands with write-back
// bypass, stalls on load-use hazards and registers the bundle for EX.
module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter  int XLEN     = 19,
  parameter  int NREG     = 8,
  parameter  int OPW      = 5,
  parameter  int ZERO_REG = 1,
  localparam int RIDX     = ridx_of(NREG)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] instr_in,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [RIDX-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_valid,
  input  logic            ex_is_load,
  input  logic [RIDX-1:0] ex_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OPW-1:0]  opcode_out,
  output logic [RIDX-1:0] rd_out,
  output logic [RIDX-1:0] rs1_out,
  output logic [RIDX-1:0] rs2_out,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] imm_out
);

  localparam int IMMW    = imm_width(XLEN, OPW, RIDX);
  localparam int RD_LSB  = rd_lsb(XLEN, OPW, RIDX);
  localparam int RS1_LSB = rs1_lsb(XLEN, OPW, RIDX);
  localparam int RS2_LSB = rs2_lsb(XLEN, OPW, RIDX);

  if (IMMW < 1) begin : g_bad_immw
    $error("id_stage_pipe: no room left for an immediate field");
  end

  logic [OPW-1:0]  w_opcode;
  logic [RIDX-1:0] w_rd, w_rs1, w_rs2;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_rs1_data, w_rs2_data;
  logic            w_src_match, w_ex_r0, w_hazard, w_accept;

  logic            r_out_valid;
  logic [OPW-1:0]  r_opcode;
  logic [RIDX-1:0] r_rd, r_rs1, r_rs2;
  logic [XLEN-1:0] r_rs1_data, r_rs2_data, r_imm;

  assign w_opcode = instr_in[XLEN-1 -: OPW];
  assign w_rd     = instr_in[RD_LSB  +: RIDX];
  assign w_rs1    = instr_in[RS1_LSB +: RIDX];
  assign w_rs2    = instr_in[RS2_LSB +: RIDX];
  assign w_imm    = {{(XLEN-IMMW){instr_in[IMMW-1]}}, instr_in[IMMW-1:0]};

  regfile_nr #(
    .XLEN     (XLEN),
    .NREG     (NREG),
    .ZERO_REG (ZERO_REG),
    .RIDX     (RIDX)
  ) u_regfile (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (wb_en),
    .waddr   (wb_rd),
    .wdata   (wb_data),
    .raddr1  (w_rs1),
    .raddr2  (w_rs2),
    .rdata1  (w_rs1_data),
    .rdata2  (w_rs2_data)
  );

  // A load into the zero register produces nothing a consumer could wait for.
  assign w_src_match = (ex_rd == w_rs1) || (ex_rd == w_rs2);
  assign w_ex_r0     = (ZERO_REG != 0) && (ex_rd == '0);
  assign w_hazard    = in_valid && ex_valid && ex_is_load && w_src_match && !w_ex_r0;

  // Flush always consumes the incoming word so IF can move past it.
  assign in_ready = flush || (!w_hazard && (!r_out_valid || out_ready));
  assign w_accept = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_opcode    <= '0;
      r_rd        <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_imm       <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_opcode    <= w_opcode;
      r_rd        <= w_rd;
      r_rs1       <= w_rs1;
      r_rs2       <= w_rs2;
      r_rs1_data  <= w_rs1_data;
      r_rs2_data  <= w_rs2_data;
      r_imm       <= w_imm;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign opcode_out = r_opcode;
  assign rd_out     = r_rd;
  assign rs1_out    = r_rs1;
  assign rs2_out    = r_rs2;
  assign rs1_data   = r_rs1_data;
  assign rs2_data   = r_rs2_data;
  assign imm_out    = r_imm;

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised decode stage for the 19-bit processor pipeline; sits between IF and EX.
- Owns the architectural register file, slices instruction fields, and reads operands with write-back bypass.
- Detects load-use hazards and inserts bubbles.
- Handshakes on both sides (valid/ready); supports branch flush.

Parameters:
- XLEN, 19, instruction and data width.
- NREG, 8, number of architectural registers (power of two, >= 2).
- OPW, 5, opcode width.
- ZERO_REG, 1, when 1 register 0 reads as zero and ignores writes.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  IF presents an instruction.
- in_ready  out  1  ID accepts the instruction this cycle.
- instr_in  in  XLEN  instruction word.
- flush  in  1  discard held and incoming instruction.
- wb_en  in  1  register write enable.
- wb_rd  in  RIDX  write index (RIDX = clog2(NREG)).
- wb_data  in  XLEN  write data.
- ex_valid  in  1  EX holds a valid instruction.
- ex_is_load  in  1  EX instruction is a load.
- ex_rd  in  RIDX  EX destination register.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  EX accepts the bundle.
- opcode_out  out  OPW  opcode.
- rd_out, rs1_out, rs2_out  out  RIDX each  register indices.
- rs1_data, rs2_data  out  XLEN each  operand values.
- imm_out  out  XLEN  sign-extended immediate.

Behaviour:
- Field layout, MSB down:
  - opcode = instr[XLEN-1 -: OPW], then rd, then rs1, then rs2 (RIDX bits each).
  - Immediate = remaining IMMW = XLEN-OPW-3*RIDX low bits, sign-extended to XLEN.
  - Defaults: opcode [18:14], rd [13:11], rs1 [10:8], rs2 [7:5], imm [4:0].
  - Elaboration error if IMMW < 1.
- Operand reads are indexed by the incoming instruction fields, combinationally in the accept cycle. Prior-cycle indices are never used.
- Bypass: if wb_en and wb_rd equals the source index (and is not r0 when ZERO_REG=1), the data output takes wb_data in the same cycle.
- Hazard:
  - hazard = in_valid & ex_valid & ex_is_load & (ex_rd == rs1 | ex_rd == rs2).
  - r0 never hazards when ZERO_REG=1.
- in_ready = !hazard & (!out_valid | out_ready). During flush, in_ready = 1 (the incoming word is consumed and dropped).
- Output register update, in priority order:
  1. flush: out_valid <= 0.
  2. Accept (in_valid & in_ready): capture all fields and data; out_valid <= 1.
  3. out_ready, no accept: out_valid <= 0 (a bubble during hazard).
  4. Otherwise: hold all outputs unchanged.
- Latency: 1 cycle from accept to out_valid.
- Data outputs are stable while out_valid & !out_ready.
- Register file:
  - Written at the clock edge when wb_en.
  - Write to r0 is ignored when ZERO_REG=1.
  - Simultaneous write and accept on the same index: the bundle carries the new data via bypass.
- Reset (reset_n low, asynchronous): out_valid, opcode_out, rd_out, rs1_out, rs2_out, rs1_data, rs2_data and imm_out all become 0, and every register is cleared. Reset mid-stall discards the held bundle.

Decomposition:
- Shared package:
  - RIDX function (clog2).
  - Field offset constants derived from XLEN/OPW/RIDX.
  - Load-opcode constant used by EX to drive ex_is_load.
- Sub-module regfile_nr:
  - NREG x XLEN, 2 combinational read ports, 1 write port.
  - Internal write-through bypass.
  - Asynchronous clear on reset_n.
  - Honours ZERO_REG.

Test Plan:
- Reset, then write r3=0x12345 via WB; accept ADD r1,r3,r2 (instr 0b00001_001_011_010_00000) -> next cycle out_valid=1, opcode_out=1, rd_out=1, rs1_data=0x12345, rs2_data=0.
- Same cycle wb_en r2=0x00ABC and accept an instruction reading r2 -> rs2_data=0x00ABC (bypass).
- ex_valid=1, ex_is_load=1, ex_rd=3, incoming rs1=3 -> in_ready=0, out_valid=0 after one cycle. Drop ex_is_load -> accepted next cycle.
- out_ready=0 for 3 cycles with out_valid=1 -> outputs unchanged, in_ready=0. Release -> next instruction captured in that cycle.
- flush with in_valid=1 -> in_ready=1, out_valid=0 next cycle. Write r0=0x7FFFF -> a later read of r0 returns 0.
- Imm field 0b10000 -> imm_out=0x7FFF0. Assert reset_n low mid-stream -> all outputs 0 immediately; registers read 0 afterwards.
